// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter.
//
// Contents:
//   arb_state_e          - arbiter FSM encoding (idle, load, wait for frame done)
//   DataWDefault         - default byte width per requester
//   ClkHz/Baud/ClksPerBit - UART timing constants for the 100 MHz system clock
//   TimeoutCyclesDefault - default watchdog limit, used only with UART_ARB_TIMEOUT_EN

package uart_arb_pkg;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StLoad     = 2'd1,
        StWaitDone = 2'd2
    } arb_state_e;

    localparam int unsigned DataWDefault = 8;

    localparam int unsigned ClkHz      = 100_000_000;
    localparam int unsigned Baud       = 9600;
    localparam int unsigned ClksPerBit = ClkHz / Baud;  // 10416

    // One 10-bit frame at 9600 baud is 104160 cycles; leave some margin.
    localparam int unsigned TimeoutCyclesDefault = 120_000;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational rotate-priority encoder.
//
// Finds the first asserted request searching cyclically from ptr+1, so the
// requester after the last winner has highest priority.
//
// Ports:
//   req   - request vector
//   ptr   - index of the last winner
//   idx   - index of the selected requester (0 when valid is low)
//   valid - at least one request is asserted

module uart_rr_pick #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic                       valid
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);

    always_comb begin
        int unsigned k;
        k     = 0;
        idx   = '0;
        valid = 1'b0;
        // Walk from the farthest candidate back to the nearest so the nearest
        // asserted request is the last one written and therefore wins.
        for (int i = NUM_REQ; i >= 1; i--) begin
            k = (32'(ptr) + 32'(i)) % NUM_REQ;
            if (req[k]) begin
                idx   = IdxW'(k);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ producers.
//
// A grant latches the winner's byte and acks it, the next cycle pulses
// tx_start, then the grant is held until tx_done. One byte per ack.
//
// Ports:
//   clk, rst  - system clock, asynchronous active-low reset
//   req, din  - per-requester request level and flattened bytes
//   ack       - one-cycle pulse, byte of requester k latched
//   tx_start  - one-cycle start pulse to the transmitter
//   tx_data   - byte to transmit, held from tx_start until tx_done
//   tx_busy   - transmitter busy level (blocks new grants)
//   tx_done   - transmitter frame-complete pulse
//   grant_id  - index of current or last winner
//   arb_busy  - high from grant until return to idle
//   err       - one-cycle watchdog pulse
//
// Build option: define UART_ARB_TIMEOUT_EN to enable the WAIT_DONE watchdog
// (TIMEOUT_CYCLES). Without it, err is constant 0 and the arbiter waits for
// tx_done indefinitely.

module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned DATA_W         = DataWDefault,
    parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDefault
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*DATA_W-1:0]  din,
    output logic [NUM_REQ-1:0]         ack,
    output logic                       tx_start,
    output logic [DATA_W-1:0]          tx_data,
    input  logic                       tx_busy,
    input  logic                       tx_done,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       arb_busy,
    output logic                       err
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               start_q, start_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [IdxW-1:0]    grant_q, grant_d;
    logic [IdxW-1:0]    ptr_q, ptr_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;

    logic [IdxW-1:0]    pick_idx;
    logic               pick_valid;
    logic               timeout;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] cnt_q;

    // Held at zero outside WAIT_DONE, so it starts from zero on every entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (state_q != StWaitDone) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Fires on the edge that completes TIMEOUT_CYCLES cycles in WAIT_DONE.
    assign timeout = (state_q == StWaitDone) && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ack_d   = '0;
        start_d = 1'b0;
        data_d  = data_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        busy_d  = busy_q;
        err_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pick_valid && !tx_busy) begin
                    data_d          = din[32'(pick_idx) * DATA_W +: DATA_W];
                    grant_d         = pick_idx;
                    ptr_d           = pick_idx;
                    ack_d[pick_idx] = 1'b1;
                    busy_d          = 1'b1;
                    state_d         = StLoad;
                end
            end
            StLoad: begin
                // Registered, so the pulse lands in the cycle after the ack.
                start_d = 1'b1;
                state_d = StWaitDone;
            end
            StWaitDone: begin
                if (tx_done) begin
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else if (timeout) begin
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            ack_q   <= '0;
            start_q <= 1'b0;
            data_q  <= '0;
            grant_q <= '0;
            ptr_q   <= IdxW'(NUM_REQ - 1);
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            start_q <= start_d;
            data_q  <= data_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign ack      = ack_q;
    assign tx_start = start_q;
    assign tx_data  = data_q;
    assign grant_id = grant_q;
    assign arb_busy = busy_q;
    assign err      = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    localparam int unsigned NumReq  = 4;
    localparam int unsigned DataW   = 8;
    localparam int unsigned Timeout = 50;
    localparam int          Frame   = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] din = '0;
    logic [3:0]  ack;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy, tx_done;
    logic [1:0]  grant_id;
    logic        arb_busy, err;

    logic tb_busy = 1'b0, tb_done = 1'b0;
    logic stub_en = 1'b0, stub_hang = 1'b0;
    logic stub_busy, stub_done;
    int   stub_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] log_data[$];
    logic [1:0] log_gid[$];
    int         log_cyc[$];
    int         err_count = 0;
    int         last_err_cyc = 0;
    logic       err_abusy = 1'b1;

    always #5 clk = ~clk;

    assign tx_busy = tb_busy | (stub_en & stub_busy);
    assign tx_done = tb_done | (stub_en & stub_done);

    uart_tx_arbiter #(
        .NUM_REQ        (NumReq),
        .DATA_W         (DataW),
        .TIMEOUT_CYCLES (Timeout)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .din      (din),
        .ack      (ack),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .grant_id (grant_id),
        .arb_busy (arb_busy),
        .err      (err)
    );

    // Transmitter stand-in: busy for Frame+1 cycles after tx_start, then tx_done.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            stub_busy <= 1'b0;
            stub_done <= 1'b0;
            stub_cnt  <= 0;
        end else begin
            stub_done <= 1'b0;
            if (err) begin
                stub_busy <= 1'b0;
            end else if (!stub_busy) begin
                if (tx_start) begin
                    stub_busy <= 1'b1;
                    stub_cnt  <= Frame;
                end
            end else if (stub_cnt != 0) begin
                stub_cnt <= stub_cnt - 1;
            end else if (!stub_hang) begin
                stub_busy <= 1'b0;
                stub_done <= 1'b1;
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst && tx_start) begin
            log_data.push_back(tx_data);
            log_gid.push_back(grant_id);
            log_cyc.push_back(cyc);
        end
        if (rst && err) begin
            err_count    = err_count + 1;
            last_err_cyc = cyc;
            err_abusy    = arb_busy;
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] log_d(input int i);
        if (i < log_data.size()) return log_data[i];
        return 8'hxx;
    endfunction

    function automatic logic [1:0] log_g(input int i);
        if (i < log_gid.size()) return log_gid[i];
        return 2'bxx;
    endfunction

    task automatic clear_log();
        log_data.delete();
        log_gid.delete();
        log_cyc.delete();
    endtask

    task automatic do_reset();
        rst     = 1'b0;
        req     = '0;
        din     = '0;
        tb_busy = 1'b0;
        tb_done = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [31:0] din;
        logic        busy;
        logic        done;
        logic [3:0]  ack;
        logic        start;
        logic [7:0]  data;
        logic [1:0]  gid;
        logic        abusy;
    } vec_t;

    localparam int NumVec = 23;
    vec_t vecs[NumVec];

    function automatic vec_t mk(input logic [3:0] r, input logic [31:0] d, input logic b,
                                input logic dn, input logic [3:0] a, input logic s,
                                input logic [7:0] td, input logic [1:0] g, input logic ab);
        vec_t v;
        v.req = r; v.din = d; v.busy = b; v.done = dn;
        v.ack = a; v.start = s; v.data = td; v.gid = g; v.abusy = ab;
        return v;
    endfunction

    int n_ack[4];

    initial begin
        // Row inputs are applied at a falling edge; expectations are the outputs
        // after the following rising edge.
        //              req      din            bsy  dn   ack      st   data   gid  abusy
        vecs[0]  = mk(4'b0001, 32'h0000_0031, 1'b0, 1'b0, 4'b0001, 1'b0, 8'h31, 2'd0, 1'b1);
        vecs[1]  = mk(4'b0000, 32'h0000_0031, 1'b0, 1'b0, 4'b0000, 1'b1, 8'h31, 2'd0, 1'b1);
        vecs[2]  = mk(4'b0000, 32'h0000_0031, 1'b1, 1'b0, 4'b0000, 1'b0, 8'h31, 2'd0, 1'b1);
        vecs[3]  = mk(4'b0000, 32'h0000_0031, 1'b1, 1'b0, 4'b0000, 1'b0, 8'h31, 2'd0, 1'b1);
        vecs[4]  = mk(4'b0000, 32'h0000_0031, 1'b0, 1'b1, 4'b0000, 1'b0, 8'h31, 2'd0, 1'b0);
        vecs[5]  = mk(4'b0010, 32'h0000_5500, 1'b1, 1'b0, 4'b0000, 1'b0, 8'h31, 2'd0, 1'b0);
        vecs[6]  = mk(4'b0010, 32'h0000_5500, 1'b1, 1'b0, 4'b0000, 1'b0, 8'h31, 2'd0, 1'b0);
        vecs[7]  = mk(4'b0010, 32'h0000_5500, 1'b0, 1'b0, 4'b0010, 1'b0, 8'h55, 2'd1, 1'b1);
        vecs[8]  = mk(4'b0000, 32'h0000_5500, 1'b0, 1'b0, 4'b0000, 1'b1, 8'h55, 2'd1, 1'b1);
        vecs[9]  = mk(4'b0000, 32'h0000_5500, 1'b0, 1'b1, 4'b0000, 1'b0, 8'h55, 2'd1, 1'b0);
        vecs[10] = mk(4'b0000, 32'h0000_5500, 1'b0, 1'b1, 4'b0000, 1'b0, 8'h55, 2'd1, 1'b0);
        vecs[11] = mk(4'b1000, 32'h7700_0000, 1'b0, 1'b0, 4'b1000, 1'b0, 8'h77, 2'd3, 1'b1);
        vecs[12] = mk(4'b0000, 32'h7700_0000, 1'b0, 1'b1, 4'b0000, 1'b1, 8'h77, 2'd3, 1'b1);
        vecs[13] = mk(4'b0000, 32'h7700_0000, 1'b0, 1'b0, 4'b0000, 1'b0, 8'h77, 2'd3, 1'b1);
        vecs[14] = mk(4'b0000, 32'h7700_0000, 1'b0, 1'b1, 4'b0000, 1'b0, 8'h77, 2'd3, 1'b0);
        vecs[15] = mk(4'b1111, 32'hA3A2_A1A0, 1'b0, 1'b0, 4'b0001, 1'b0, 8'hA0, 2'd0, 1'b1);
        vecs[16] = mk(4'b1110, 32'hA3A2_A1A0, 1'b0, 1'b0, 4'b0000, 1'b1, 8'hA0, 2'd0, 1'b1);
        vecs[17] = mk(4'b1110, 32'hA3A2_A1A0, 1'b0, 1'b1, 4'b0000, 1'b0, 8'hA0, 2'd0, 1'b0);
        vecs[18] = mk(4'b1110, 32'hA3A2_A1A0, 1'b0, 1'b0, 4'b0010, 1'b0, 8'hA1, 2'd1, 1'b1);
        vecs[19] = mk(4'b0000, 32'hA3A2_A1A0, 1'b0, 1'b0, 4'b0000, 1'b1, 8'hA1, 2'd1, 1'b1);
        vecs[20] = mk(4'b0000, 32'hA3A2_A1A0, 1'b0, 1'b1, 4'b0000, 1'b0, 8'hA1, 2'd1, 1'b0);
        vecs[21] = mk(4'b0100, 32'hA3A2_A1A0, 1'b1, 1'b0, 4'b0000, 1'b0, 8'hA1, 2'd1, 1'b0);
        vecs[22] = mk(4'b0000, 32'hA3A2_A1A0, 1'b0, 1'b0, 4'b0000, 1'b0, 8'hA1, 2'd1, 1'b0);

        // Reset state.
        do_reset();
        check("reset ack", 32'(ack), 32'h0);
        check("reset tx_start", 32'(tx_start), 32'h0);
        check("reset tx_data", 32'(tx_data), 32'h0);
        check("reset grant_id", 32'(grant_id), 32'h0);
        check("reset arb_busy", 32'(arb_busy), 32'h0);
        check("reset err", 32'(err), 32'h0);

        // Cycle-by-cycle vector table: latency, busy blocking, spurious tx_done.
        for (int i = 0; i < NumVec; i++) begin
            req     = vecs[i].req;
            din     = vecs[i].din;
            tb_busy = vecs[i].busy;
            tb_done = vecs[i].done;
            @(negedge clk);
            check($sformatf("vec%0d ack", i), 32'(ack), 32'(vecs[i].ack));
            check($sformatf("vec%0d tx_start", i), 32'(tx_start), 32'(vecs[i].start));
            check($sformatf("vec%0d tx_data", i), 32'(tx_data), 32'(vecs[i].data));
            check($sformatf("vec%0d grant_id", i), 32'(grant_id), 32'(vecs[i].gid));
            check($sformatf("vec%0d arb_busy", i), 32'(arb_busy), 32'(vecs[i].abusy));
        end

        // Simultaneous requests right after reset, each dropping after its ack.
        do_reset();
        stub_en = 1'b1;
        clear_log();
        req = 4'b1111;
        din = 32'hA3A2_A1A0;
        for (int c = 0; c < 400 && !(log_data.size() == 4 && !arb_busy); c++) begin
            @(negedge clk);
            req = req & ~ack;
        end
        check("all4 frame count", 32'(log_data.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("all4 gid%0d", i), 32'(log_g(i)), 32'(i));
            check($sformatf("all4 byte%0d", i), 32'(log_d(i)), 32'(8'hA0 + 8'(i)));
        end

        // Fairness: requester 2 starts alone, then 0 and 3 join; all stay asserted.
        clear_log();
        for (int k = 0; k < 4; k++) n_ack[k] = 0;
        din = {8'h30, 8'h20, 8'h10, 8'h00};
        req = 4'b0100;
        for (int c = 0; c < 600 && log_data.size() < 6; c++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                if (ack[k]) begin
                    n_ack[k]++;
                    din[k*8 +: 8] = 8'(k * 16 + n_ack[k]);
                    if (k == 2) req = 4'b1101;
                end
            end
        end
        req = '0;
        for (int c = 0; c < 100 && arb_busy; c++) @(negedge clk);
        begin
            logic [1:0] exp_g[6];
            logic [7:0] exp_d[6];
            exp_g = '{2'd2, 2'd3, 2'd0, 2'd2, 2'd3, 2'd0};
            exp_d = '{8'h20, 8'h30, 8'h00, 8'h21, 8'h31, 8'h01};
            check("fair frame count", 32'(log_data.size() >= 6), 32'd1);
            for (int i = 0; i < 6; i++) begin
                check($sformatf("fair gid%0d", i), 32'(log_g(i)), 32'(exp_g[i]));
                check($sformatf("fair byte%0d", i), 32'(log_d(i)), 32'(exp_d[i]));
            end
        end

        // Reset mid-frame: requester 1 in flight, then reset aborts it.
        clear_log();
        req = 4'b0010;
        din = 32'h0000_5A00;
        for (int c = 0; c < 200 && !(stub_busy && stub_cnt == 6); c++) begin
            @(negedge clk);
            req = req & ~ack;
        end
        check("midframe in flight", 32'(arb_busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("midreset ack", 32'(ack), 32'h0);
        check("midreset tx_start", 32'(tx_start), 32'h0);
        check("midreset tx_data", 32'(tx_data), 32'h0);
        check("midreset grant_id", 32'(grant_id), 32'h0);
        check("midreset arb_busy", 32'(arb_busy), 32'h0);
        check("midreset err", 32'(err), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        clear_log();
        req = 4'b0111;
        din = 32'h00C2_C1C0;
        for (int c = 0; c < 400 && !(log_data.size() == 3 && !arb_busy); c++) begin
            @(negedge clk);
            req = req & ~ack;
        end
        check("postreset gid0", 32'(log_g(0)), 32'd0);
        check("postreset byte0", 32'(log_d(0)), 32'hC0);
        check("postreset gid1", 32'(log_g(1)), 32'd1);

`ifdef UART_ARB_TIMEOUT_EN
        // Watchdog: transmitter never completes; next requester is served after err.
        clear_log();
        stub_hang = 1'b1;
        req = 4'b0011;
        din = 32'h0000_E1E0;
        for (int c = 0; c < 400 && !(log_data.size() >= 2 && !arb_busy); c++) begin
            @(negedge clk);
            req = req & ~ack;
            if (err) stub_hang = 1'b0;
        end
        check("timeout first gid", 32'(log_g(0)), 32'd0);
        check("timeout err delay", 32'(last_err_cyc - (log_cyc.size() > 0 ? log_cyc[0] : 0)),
              32'(Timeout));
        check("timeout arb_busy at err", 32'(err_abusy), 32'd0);
        check("timeout next gid", 32'(log_g(1)), 32'd1);
        check("timeout next byte", 32'(log_d(1)), 32'hE1);
        check("err pulse count", 32'(err_count), 32'd1);
`else
        check("err pulse count", 32'(err_count), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
